// File: rtl/friscv_icache_linefill.sv
// rtl/friscv_icache_linefill.sv - instruction-cache line-fill and FENCE.i erase controller
module friscv_icache_linefill #(
    parameter int AXI_ADDR_W    = 32,
    parameter int AXI_ID_W      = 8,
    parameter int AXI_DATA_W    = 32,
    parameter int CACHE_BLOCK_W = 128,
    parameter int CACHE_DEPTH   = 512,
    parameter int MAX_OSTDREQ   = 4
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     flush_req,
    output logic                     flush_ack,
    output logic                     flush,
    input  logic                     ctrl_arvalid,
    output logic                     ctrl_arready,
    input  logic [AXI_ADDR_W-1:0]    ctrl_araddr,
    input  logic [2:0]               ctrl_arprot,
    input  logic [AXI_ID_W-1:0]      ctrl_arid,
    output logic                     mem_arvalid,
    input  logic                     mem_arready,
    output logic [AXI_ADDR_W-1:0]    mem_araddr,
    output logic [7:0]               mem_arlen,
    output logic [2:0]               mem_arsize,
    output logic [1:0]               mem_arburst,
    output logic [1:0]               mem_arlock,
    output logic [3:0]               mem_arcache,
    output logic [2:0]               mem_arprot,
    output logic [3:0]               mem_arqos,
    output logic [3:0]               mem_arregion,
    output logic [AXI_ID_W-1:0]      mem_arid,
    input  logic                     mem_rvalid,
    output logic                     mem_rready,
    input  logic [AXI_ID_W-1:0]      mem_rid,
    input  logic [1:0]               mem_rresp,
    input  logic [AXI_DATA_W-1:0]    mem_rdata,
    input  logic                     mem_rlast,
    output logic                     cache_wen,
    output logic [AXI_ADDR_W-1:0]    cache_waddr,
    output logic [CACHE_BLOCK_W-1:0] cache_wdata,
    output logic                     fill_err,
    output logic [AXI_ADDR_W-1:0]    fill_err_addr
);

    localparam int NBEAT  = CACHE_BLOCK_W / AXI_DATA_W;
    localparam int LB     = $clog2(CACHE_BLOCK_W / 8);
    localparam int ARSIZE = $clog2(AXI_DATA_W / 8);
    localparam int CNT_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int PTR_W  = (MAX_OSTDREQ > 1) ? $clog2(MAX_OSTDREQ) : 1;
    localparam int IDX_W  = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CACHE_DEPTH - 1);
    localparam logic [PTR_W:0]   FIFO_CAP  = (PTR_W + 1)'(MAX_OSTDREQ);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, ACK} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [CACHE_BLOCK_W-1:0] line_q, line_d, line_merged;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]           count_q, count_d;
    logic [AXI_ADDR_W-1:0]    fifo_mem [MAX_OSTDREQ];
    logic                     fill_done_q, fill_done_d;
    logic                     cache_wen_q, cache_wen_d;
    logic [AXI_ADDR_W-1:0]    cache_waddr_q, cache_waddr_d;
    logic [CACHE_BLOCK_W-1:0] cache_wdata_q, cache_wdata_d;
    logic                     fill_err_q, fill_err_d;
    logic [AXI_ADDR_W-1:0]    fill_err_addr_q, fill_err_addr_d;
    logic                     flush_q, flush_d;
    logic                     flush_ack_q, flush_ack_d;

    logic                  ar_gate, push, pop, r_hs, beat_last, line_done, line_bad;
    logic                  fifo_full, fifo_empty;
    logic [AXI_ADDR_W-1:0] fifo_head;
    logic                  unused_sig;

    assign fifo_full  = (count_q == FIFO_CAP);
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    assign ar_gate      = !srst && (state_q == IDLE) && !flush_req && !fifo_full;
    assign mem_arvalid  = ctrl_arvalid & ar_gate;
    assign ctrl_arready = mem_arready & ar_gate;
    assign mem_araddr   = {ctrl_araddr[AXI_ADDR_W-1:LB], {LB{1'b0}}};
    assign mem_arlen    = 8'(NBEAT - 1);
    assign mem_arsize   = 3'(ARSIZE);
    assign mem_arburst  = 2'b01;
    assign mem_arlock   = 2'b00;
    assign mem_arcache  = 4'b0000;
    assign mem_arqos    = 4'b0000;
    assign mem_arregion = 4'b0000;
    assign mem_arprot   = ctrl_arprot;
    assign mem_arid     = ctrl_arid;
    assign push         = mem_arvalid & mem_arready;

    // Responses arrive in request order, so the ID carries no information here.
    assign unused_sig = ^{mem_rid, ctrl_araddr[LB-1:0]};

    assign mem_rready = !srst;
    assign r_hs       = mem_rvalid & mem_rready;
    assign beat_last  = (cnt_q == LAST_BEAT);
    assign line_done  = r_hs & (beat_last | mem_rlast);
    assign line_bad   = err_q | (mem_rresp != 2'b00) | (mem_rlast != beat_last);
    assign pop        = line_done & !fifo_empty;

    always_comb begin
        line_merged = line_q;
        if (r_hs) begin
            line_merged[int'(cnt_q) * AXI_DATA_W +: AXI_DATA_W] = mem_rdata;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        line_d          = line_q;
        wr_ptr_d        = wr_ptr_q + PTR_W'(push);
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
        count_d         = count_q;
        fill_done_d     = 1'b0;
        cache_wen_d     = 1'b0;
        cache_waddr_d   = cache_waddr_q;
        cache_wdata_d   = cache_wdata_q;
        fill_err_d      = 1'b0;
        fill_err_addr_d = fill_err_addr_q;
        flush_d         = 1'b0;
        flush_ack_d     = 1'b0;

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (r_hs) begin
            if (line_done) begin
                cnt_d  = '0;
                err_d  = 1'b0;
                line_d = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                err_d  = err_q | (mem_rresp != 2'b00);
                line_d = line_merged;
            end
        end

        if (pop) begin
            fill_done_d = 1'b1;
            if (line_bad) begin
                fill_err_d      = 1'b1;
                fill_err_addr_d = fifo_head;
            end else begin
                cache_wen_d   = 1'b1;
                cache_waddr_d = fifo_head;
                cache_wdata_d = line_merged;
            end
        end

        // DRAIN keeps fills and erase writes from ever sharing a cycle.
        case (state_q)
            IDLE: begin
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !fill_done_q) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                end
            end
            FLUSH: begin
                flush_d       = 1'b1;
                cache_wen_d   = 1'b1;
                cache_waddr_d = AXI_ADDR_W'(idx_q) << LB;
                cache_wdata_d = '0;
                idx_d         = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) state_d = ACK;
            end
            ACK: begin
                if (flush_req) flush_ack_d = 1'b1;
                else           state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            line_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fill_done_q     <= 1'b0;
            cache_wen_q     <= 1'b0;
            cache_waddr_q   <= '0;
            cache_wdata_q   <= '0;
            fill_err_q      <= 1'b0;
            fill_err_addr_q <= '0;
            flush_q         <= 1'b0;
            flush_ack_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            line_q          <= line_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            fill_done_q     <= fill_done_d;
            cache_wen_q     <= cache_wen_d;
            cache_waddr_q   <= cache_waddr_d;
            cache_wdata_q   <= cache_wdata_d;
            fill_err_q      <= fill_err_d;
            fill_err_addr_q <= fill_err_addr_d;
            flush_q         <= flush_d;
            flush_ack_q     <= flush_ack_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_araddr;
    end

    assign cache_wen     = cache_wen_q;
    assign cache_waddr   = cache_waddr_q;
    assign cache_wdata   = cache_wdata_q;
    assign fill_err      = fill_err_q;
    assign fill_err_addr = fill_err_addr_q;
    assign flush         = flush_q;
    assign flush_ack     = flush_ack_q;

endmodule

// File: tb/tb_friscv_icache_linefill.sv
// tb/tb_friscv_icache_linefill.sv - scoreboard bench for the line-fill controller
module tb_friscv_icache_linefill;

    logic         aclk = 0;
    logic         srst = 1;
    logic         flush_req = 0;
    logic         flush_ack, flush;
    logic         ctrl_arvalid = 0;
    logic         ctrl_arready;
    logic [31:0]  ctrl_araddr = 0;
    logic [2:0]   ctrl_arprot = 0;
    logic [7:0]   ctrl_arid = 0;
    logic         mem_arvalid;
    logic         mem_arready = 0;
    logic [31:0]  mem_araddr;
    logic [7:0]   mem_arlen;
    logic [2:0]   mem_arsize;
    logic [1:0]   mem_arburst;
    logic [1:0]   mem_arlock;
    logic [3:0]   mem_arcache;
    logic [2:0]   mem_arprot;
    logic [3:0]   mem_arqos;
    logic [3:0]   mem_arregion;
    logic [7:0]   mem_arid;
    logic         mem_rvalid = 0;
    logic         mem_rready;
    logic [7:0]   mem_rid = 0;
    logic [1:0]   mem_rresp = 0;
    logic [31:0]  mem_rdata = 0;
    logic         mem_rlast = 0;
    logic         cache_wen;
    logic [31:0]  cache_waddr;
    logic [127:0] cache_wdata;
    logic         fill_err;
    logic [31:0]  fill_err_addr;

    friscv_icache_linefill dut (
        .aclk(aclk), .srst(srst), .flush_req(flush_req), .flush_ack(flush_ack), .flush(flush),
        .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready), .ctrl_araddr(ctrl_araddr),
        .ctrl_arprot(ctrl_arprot), .ctrl_arid(ctrl_arid),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
        .mem_arlock(mem_arlock), .mem_arcache(mem_arcache), .mem_arprot(mem_arprot),
        .mem_arqos(mem_arqos), .mem_arregion(mem_arregion), .mem_arid(mem_arid),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rid(mem_rid),
        .mem_rresp(mem_rresp), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
        .fill_err(fill_err), .fill_err_addr(fill_err_addr)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit           err;
        logic [31:0]  addr;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   erase_cnt = 0;

    // Scoreboard monitor: fill writes and fill errors pop expectations; erase writes follow a bench index.
    always @(negedge aclk) begin
        if (!srst) begin
            if (cache_wen && flush) begin
                checks++;
                if (cache_waddr !== 32'(erase_cnt * 16) || cache_wdata !== 128'h0) begin
                    errors++;
                    $display("FAIL erase_write idx=%0d got addr=%h data=%h want addr=%h data=0",
                             erase_cnt, cache_waddr, cache_wdata, 32'(erase_cnt * 16));
                end
                if (erase_cnt == 0) begin
                    checks++;
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL erase_before_drain pending=%0d want 0", exp_q.size());
                    end
                end
                erase_cnt++;
            end else if (cache_wen || fill_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_completion wen=%b err=%b addr=%h", cache_wen, fill_err,
                             cache_wen ? cache_waddr : fill_err_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cache_wen && fill_err) begin
                        errors++;
                        $display("FAIL completion_both wen=1 err=1 want only one");
                    end else if (e.err && !fill_err) begin
                        errors++;
                        $display("FAIL fill_kind got write addr=%h want fill_err addr=%h", cache_waddr, e.addr);
                    end else if (!e.err && !cache_wen) begin
                        errors++;
                        $display("FAIL fill_kind got fill_err addr=%h want write addr=%h", fill_err_addr, e.addr);
                    end else if (e.err && fill_err_addr !== e.addr) begin
                        errors++;
                        $display("FAIL fill_err_addr got %h want %h", fill_err_addr, e.addr);
                    end else if (!e.err && (cache_waddr !== e.addr || cache_wdata !== e.data)) begin
                        errors++;
                        $display("FAIL fill_write got addr=%h data=%h want addr=%h data=%h",
                                 cache_waddr, cache_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] a, output bit ok);
        ok = 0;
        ctrl_araddr  = a;
        ctrl_arvalid = 1;
        mem_arready  = 1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ctrl_arready) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        ctrl_arvalid = 0;
        mem_arready  = 0;
    endtask

    task automatic issue(input string name, input logic [31:0] a);
        bit ok;
        do_ar(a, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ar_handshake addr=%h got no accept want accept", name, a);
        end
    endtask

    // Drives beats 0..last_beat; bad_beat<0 means all OKAY responses.
    task automatic send_burst(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int bad_beat, input int last_beat);
        logic [31:0] d [4];
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        e.addr = {a[31:4], 4'h0};
        e.data = {d3, d2, d1, d0};
        e.err  = (last_beat != 3) || (bad_beat >= 0 && bad_beat <= last_beat);
        exp_q.push_back(e);
        for (int k = 0; k <= last_beat; k++) begin
            mem_rvalid = 1;
            mem_rdata  = d[k];
            mem_rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
            mem_rlast  = (k == last_beat);
            tick();
        end
        mem_rvalid = 0;
        mem_rlast  = 0;
        mem_rresp  = 0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        srst = 1;
        ctrl_arvalid = 1;
        mem_arready  = 1;
        ctrl_araddr  = 32'h100;
        tick(); tick();
        checks++;
        if (ctrl_arready !== 0 || mem_arvalid !== 0 || mem_rready !== 0) begin
            errors++;
            $display("FAIL reset_gates got arready=%b arvalid=%b rready=%b want 0 0 0",
                     ctrl_arready, mem_arvalid, mem_rready);
        end
        ctrl_arvalid = 0;
        mem_arready  = 0;
        srst = 0;
        tick();
        checks++;
        if (cache_wen !== 0 || fill_err !== 0 || flush !== 0 || flush_ack !== 0 || mem_rready !== 1) begin
            errors++;
            $display("FAIL reset_outputs got wen=%b err=%b flush=%b ack=%b rready=%b want 0 0 0 0 1",
                     cache_wen, fill_err, flush, flush_ack, mem_rready);
        end
    endtask

    task automatic test_single();
        ctrl_araddr  = 32'h1234;
        ctrl_arvalid = 1;
        ctrl_arid    = 8'h5A;
        ctrl_arprot  = 3'b101;
        #1;
        checks++;
        if (mem_arvalid !== 1 || mem_araddr !== 32'h1230 || mem_arlen !== 8'd3 || mem_arsize !== 3'd2 ||
            mem_arburst !== 2'd1 || mem_arid !== 8'h5A || mem_arprot !== 3'b101 || mem_arcache !== 0) begin
            errors++;
            $display("FAIL ar_fields got v=%b addr=%h len=%0d size=%0d burst=%0d id=%h prot=%b want 1 1230 3 2 1 5a 101",
                     mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arid, mem_arprot);
        end
        tick();
        issue("single", 32'h1234);
        send_burst(32'h1230, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, -1, 3);
        checks++;
        if (cache_wen !== 1 || cache_waddr !== 32'h1230) begin
            errors++;
            $display("FAIL single_latency got wen=%b addr=%h want 1 1230", cache_wen, cache_waddr);
        end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 4; i++) issue("b2b", 32'(i * 16));
        do_ar(32'h40, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL b2b_fifo_full got 5th accepted want stalled");
        end
        for (int i = 0; i < 4; i++)
            send_burst(32'(i * 16), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), -1, 3);
        wait_drain("b2b");
        ctrl_arvalid = 1;
        mem_arready  = 1;
        #1;
        checks++;
        if (ctrl_arready !== 1) begin
            errors++;
            $display("FAIL b2b_reopen got arready=%b want 1", ctrl_arready);
        end
        ctrl_arvalid = 0;
        mem_arready  = 0;
        tick();
    endtask

    task automatic test_rresp_err();
        issue("rresp", 32'h40);
        issue("rresp", 32'h50);
        send_burst(32'h40, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2, 3);
        send_burst(32'h50, 32'hB0, 32'hB1, 32'hB2, 32'hB3, -1, 3);
        wait_drain("rresp");
    endtask

    task automatic test_early_last();
        issue("early", 32'h60);
        issue("early", 32'h74);
        send_burst(32'h60, 32'hC0, 32'hC1, 32'hC2, 32'hC3, -1, 1);
        send_burst(32'h70, 32'hD0, 32'hD1, 32'hD2, 32'hD3, -1, 3);
        wait_drain("early");
    endtask

    task automatic test_flush();
        int i;
        issue("flush", 32'h80);
        issue("flush", 32'h90);
        flush_req    = 1;
        ctrl_arvalid = 1;
        mem_arready  = 1;
        ctrl_araddr  = 32'hA0;
        #1;
        checks++;
        if (ctrl_arready !== 0) begin
            errors++;
            $display("FAIL flush_blocks_ar got arready=%b want 0", ctrl_arready);
        end
        ctrl_arvalid = 0;
        mem_arready  = 0;
        tick();
        erase_cnt = 0;
        send_burst(32'h80, 32'hE0, 32'hE1, 32'hE2, 32'hE3, -1, 3);
        send_burst(32'h90, 32'hF0, 32'hF1, 32'hF2, 32'hF3, -1, 3);
        for (i = 0; i < 700 && flush_ack !== 1; i++) tick();
        checks++;
        if (flush_ack !== 1 || erase_cnt != 512) begin
            errors++;
            $display("FAIL flush_sweep got ack=%b erases=%0d want ack=1 erases=512", flush_ack, erase_cnt);
        end
        tick(); tick();
        checks++;
        if (flush_ack !== 1 || erase_cnt != 512) begin
            errors++;
            $display("FAIL flush_ack_hold got ack=%b erases=%0d want 1 512", flush_ack, erase_cnt);
        end
        flush_req = 0;
        tick();
        ctrl_arvalid = 1;
        mem_arready  = 1;
        #1;
        checks++;
        if (flush_ack !== 0 || ctrl_arready !== 1) begin
            errors++;
            $display("FAIL flush_release got ack=%b arready=%b want 0 1", flush_ack, ctrl_arready);
        end
        ctrl_arvalid = 0;
        mem_arready  = 0;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        erase_cnt = 0;
        flush_req = 1;
        for (int i = 0; i < 300 && erase_cnt < 100; i++) tick();
        checks++;
        if (erase_cnt != 100) begin
            errors++;
            $display("FAIL sweep_progress got erases=%0d want 100", erase_cnt);
        end
        srst = 1;
        tick();
        checks++;
        if (cache_wen !== 0 || flush !== 0 || flush_ack !== 0 || fill_err !== 0 || cache_waddr !== 0) begin
            errors++;
            $display("FAIL mid_reset_outputs got wen=%b flush=%b ack=%b err=%b waddr=%h want all 0",
                     cache_wen, flush, flush_ack, fill_err, cache_waddr);
        end
        flush_req = 0;
        srst = 0;
        tick();
        tick();
        checks++;
        if (flush !== 0 || cache_wen !== 0) begin
            errors++;
            $display("FAIL mid_reset_idle got flush=%b wen=%b want 0 0", flush, cache_wen);
        end
        issue("post_reset", 32'h2468);
        send_burst(32'h2460, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, -1, 3);
        wait_drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rresp_err();
        test_early_last();
        test_flush();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
